// File: rtl/tracker_sweep_sequencer_pkg.sv
// Shared encodings and default timing for the solar tracker calibration sequencer.
package tracker_sweep_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HS   = 3'd1,
    ST_HM   = 3'd2,
    ST_VS   = 3'd3,
    ST_VM   = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_INC  = 2'b01;
  localparam logic [1:0] DIR_DEC  = 2'b10;

  localparam int unsigned PW_MIN_DEF     = 32'd5000;
  localparam int unsigned PW_LIMIT_DEF   = 32'd25000;
  localparam int unsigned IRR_W_DEF      = 32'd12;
  localparam int unsigned SETTLE_CYC_DEF = 32'd3000000;
  localparam int unsigned RECAL_CYC_DEF  = 32'd600000000;

  function automatic logic is_sweep(input state_e s);
    return (s == ST_HS) || (s == ST_VS);
  endfunction

endpackage

// File: rtl/tracker_sweep_sequencer_irr_peak_tracker.sv
// Tracks the brightest irradiance seen during one axis sweep and the pulse width where it occurred.
module irr_peak_tracker #(
  parameter int unsigned IRR_W  = 12,
  parameter int unsigned PW_MIN = 5000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             sample,
  input  logic [IRR_W-1:0] irr,
  input  logic [31:0]      pw,
  output logic [31:0]      peak_nxt
);

  logic [IRR_W-1:0] best_q, best_d;
  logic [31:0]      peak_q, peak_d;

  // Strictly-greater update so ties keep the earlier, lower position.
  always_comb begin
    best_d = best_q;
    peak_d = peak_q;
    if (clr) begin
      best_d = '0;
      peak_d = 32'(PW_MIN);
    end else if (sample && (irr > best_q)) begin
      best_d = irr;
      peak_d = pw;
    end else begin
      best_d = best_q;
      peak_d = peak_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      best_q <= '0;
      peak_q <= 32'(PW_MIN);
    end else begin
      best_q <= best_d;
      peak_q <= peak_d;
    end
  end

  assign peak_nxt = peak_d;

endmodule

// File: rtl/tracker_sweep_sequencer.sv
// Calibration sequencer: sweeps H then V servo, returns each to its brightest position.
// Optional ST_AUTO_RECAL_EN: restarts calibration after RECAL_CYC idle cycles.
module tracker_sweep_sequencer
  import tracker_sweep_sequencer_pkg::*;
#(
  parameter int unsigned PW_MIN     = PW_MIN_DEF,
  parameter int unsigned PW_LIMIT   = PW_LIMIT_DEF,
  parameter int unsigned IRR_W      = IRR_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
`ifdef ST_AUTO_RECAL_EN
  , parameter int unsigned RECAL_CYC = RECAL_CYC_DEF
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [IRR_W-1:0] IRR,
  input  logic             IRR_VALID,
  input  logic [31:0]      PW_H,
  input  logic [31:0]      PW_V,
  output logic [1:0]       DIR_H,
  output logic [1:0]       DIR_V,
  output logic             EN_H,
  output logic             EN_V,
  output logic             ES,
  output logic             MC_H,
  output logic             MC_V,
  output logic [31:0]      PW_MAX_H,
  output logic [31:0]      PW_MAX_V,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       STATE
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  dir_h_q, dir_h_d, dir_v_q, dir_v_d;
  logic        en_h_q, en_h_d, en_v_q, en_v_d, es_q, es_d;
  logic        mc_h_q, mc_h_d, mc_v_q, mc_v_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] pw_max_h_q, pw_max_h_d, pw_max_v_q, pw_max_v_d;
  logic        trk_clr, trk_sample;
  logic [31:0] trk_pw, trk_peak_nxt;
  logic        recal_hit;

`ifdef ST_AUTO_RECAL_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = 32'd0;
    if ((state_q == ST_IDLE) && (state_d == ST_IDLE)) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end else begin
      idle_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign recal_hit = (idle_cnt_q == 32'(RECAL_CYC - 1));
`else
  assign recal_hit = 1'b0;
`endif

  // Next-state and settle counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (START || recal_hit) state_d = ST_HS;
        else                    state_d = ST_IDLE;
      end
      ST_HS: begin
        if (PW_H >= 32'(PW_LIMIT)) state_d = ST_HM;
        else                       state_d = ST_HS;
      end
      ST_HM: begin
        if (cnt_q == 32'(SETTLE_CYC - 1)) state_d = ST_VS;
        else                              state_d = ST_HM;
      end
      ST_VS: begin
        if (PW_V >= 32'(PW_LIMIT)) state_d = ST_VM;
        else                       state_d = ST_VS;
      end
      ST_VM: begin
        if (cnt_q == 32'(SETTLE_CYC - 1)) state_d = ST_FIN;
        else                              state_d = ST_VM;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    cnt_d = 32'd0;
    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end else if ((state_q == ST_HM) || (state_q == ST_VM)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = 32'd0;
    end
  end

  assign trk_clr    = is_sweep(state_d) && (state_d != state_q);
  assign trk_sample = is_sweep(state_q) && IRR_VALID;
  assign trk_pw     = (state_q == ST_VS) ? PW_V : PW_H;

  irr_peak_tracker #(
    .IRR_W  (IRR_W),
    .PW_MIN (PW_MIN)
  ) u_peak (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (trk_clr),
    .sample   (trk_sample),
    .irr      (IRR),
    .pw       (trk_pw),
    .peak_nxt (trk_peak_nxt)
  );

  // Outputs decoded from the next state so they change on the same edge as STATE.
  always_comb begin
    dir_h_d = DIR_STOP;
    dir_v_d = DIR_STOP;
    en_h_d  = 1'b0;
    en_v_d  = 1'b0;
    es_d    = 1'b0;
    mc_h_d  = 1'b0;
    mc_v_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_d)
      ST_IDLE: busy_d = 1'b0;
      ST_HS: begin
        en_h_d = 1'b1; dir_h_d = DIR_INC; es_d = 1'b1;
      end
      ST_HM: begin
        en_h_d = 1'b1; dir_h_d = DIR_DEC; mc_h_d = 1'b1;
      end
      ST_VS: begin
        en_h_d = 1'b1; dir_h_d = DIR_DEC; mc_h_d = 1'b1;
        en_v_d = 1'b1; dir_v_d = DIR_INC; es_d   = 1'b1;
      end
      ST_VM: begin
        en_h_d = 1'b1; dir_h_d = DIR_DEC; mc_h_d = 1'b1;
        en_v_d = 1'b1; dir_v_d = DIR_DEC; mc_v_d = 1'b1;
      end
      ST_FIN:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase

    if ((state_q == ST_HS) || (state_d == ST_HS)) pw_max_h_d = trk_peak_nxt;
    else                                          pw_max_h_d = pw_max_h_q;
    if ((state_q == ST_VS) || (state_d == ST_VS)) pw_max_v_d = trk_peak_nxt;
    else                                          pw_max_v_d = pw_max_v_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      dir_h_q    <= DIR_STOP;
      dir_v_q    <= DIR_STOP;
      en_h_q     <= 1'b0;
      en_v_q     <= 1'b0;
      es_q       <= 1'b0;
      mc_h_q     <= 1'b0;
      mc_v_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pw_max_h_q <= 32'(PW_MIN);
      pw_max_v_q <= 32'(PW_MIN);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_h_q    <= dir_h_d;
      dir_v_q    <= dir_v_d;
      en_h_q     <= en_h_d;
      en_v_q     <= en_v_d;
      es_q       <= es_d;
      mc_h_q     <= mc_h_d;
      mc_v_q     <= mc_v_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pw_max_h_q <= pw_max_h_d;
      pw_max_v_q <= pw_max_v_d;
    end
  end

  assign DIR_H    = dir_h_q;
  assign DIR_V    = dir_v_q;
  assign EN_H     = en_h_q;
  assign EN_V     = en_v_q;
  assign ES       = es_q;
  assign MC_H     = mc_h_q;
  assign MC_V     = mc_v_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PW_MAX_H = pw_max_h_q;
  assign PW_MAX_V = pw_max_v_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_tracker_sweep_sequencer.sv
// Bench for tracker_sweep_sequencer: table of sweep profiles plus reset/idle sequences.
module tb_tracker_sweep_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, IRR_VALID;
  logic [11:0] IRR;
  logic [31:0] PW_H, PW_V;
  logic [1:0]  DIR_H, DIR_V;
  logic        EN_H, EN_V, ES, MC_H, MC_V, BUSY, DONE;
  logic [31:0] PW_MAX_H, PW_MAX_V;
  logic [2:0]  STATE;

  always #5 CLK = ~CLK;

  tracker_sweep_sequencer #(
    .PW_MIN(5000), .PW_LIMIT(25000), .IRR_W(12), .SETTLE_CYC(10)
`ifdef ST_AUTO_RECAL_EN
    , .RECAL_CYC(50)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .IRR(IRR), .IRR_VALID(IRR_VALID),
    .PW_H(PW_H), .PW_V(PW_V), .DIR_H(DIR_H), .DIR_V(DIR_V), .EN_H(EN_H), .EN_V(EN_V),
    .ES(ES), .MC_H(MC_H), .MC_V(MC_V), .PW_MAX_H(PW_MAX_H), .PW_MAX_V(PW_MAX_V),
    .BUSY(BUSY), .DONE(DONE), .STATE(STATE)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int h1_pw; int h1_irr; int h2_pw; int h2_irr; int base;
    int v_pw;  int v_irr;  int exp_h; int exp_v;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [31:0] act);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %0d", name, act);
    end else begin
      check(name, act, sb_q.pop_front());
    end
  endtask

  // One step per cycle from 0 deg to 180 deg; a stray START mid-sweep must be ignored.
  task automatic drive_ramp(input bit horiz, input vec_t v);
    int irr;
    for (int pw = 5000; pw <= 25000; pw += 1000) begin
      irr = v.base;
      if (horiz) begin
        PW_H = pw;
        if (pw == v.h1_pw) irr = v.h1_irr;
        else if (pw == v.h2_pw) irr = v.h2_irr;
      end else begin
        PW_V = pw;
        if (pw == v.v_pw) irr = v.v_irr;
      end
      IRR       = irr[11:0];
      IRR_VALID = 1'b1;
      START     = (pw == 10000);
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  task automatic wait_leave(input logic [2:0] s, input int bound, output int n);
    n = 0;
    while ((STATE == s) && (n < bound)) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, STATE, 0);
    check({tag, "_dir"}, {DIR_H, DIR_V}, 0);
    check({tag, "_flags"}, {EN_H, EN_V, ES, MC_H, MC_V, BUSY, DONE}, 0);
    check({tag, "_pwmaxh"}, PW_MAX_H, 5000);
    check({tag, "_pwmaxv"}, PW_MAX_V, 5000);
  endtask

  task automatic run_cal(input vec_t v);
    int n;
    sb_q.push_back(v.exp_h);
    sb_q.push_back(v.exp_v);
    PW_H = 0;
    PW_V = 0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("hs_state", STATE, 1);
    check("hs_outs", {DIR_H, ES, BUSY, EN_H, MC_H}, {2'b01, 1'b1, 1'b1, 1'b1, 1'b0});
    drive_ramp(1'b1, v);
    check("hm_state", STATE, 2);
    check("hm_outs", {DIR_H, ES, MC_H, EN_H}, {2'b10, 1'b0, 1'b1, 1'b1});
    pop_check("pw_max_h", PW_MAX_H);
    IRR = 12'd4095;
    IRR_VALID = 1'b1;
    wait_leave(3'd2, 100, n);
    check("hm_len", n, 10);
    check("vs_state", STATE, 3);
    check("vs_outs", {DIR_H, DIR_V, ES, MC_H, EN_V}, {2'b10, 2'b01, 1'b1, 1'b1, 1'b1});
    drive_ramp(1'b0, v);
    check("vm_state", STATE, 4);
    check("vm_outs", {DIR_V, MC_V, ES}, {2'b10, 1'b1, 1'b0});
    pop_check("pw_max_v", PW_MAX_V);
    check("pw_max_h_hold", PW_MAX_H, v.exp_h);
    IRR = 12'd4095;
    wait_leave(3'd4, 100, n);
    IRR_VALID = 1'b0;
    check("vm_len", n, 10);
    check("fin_state", STATE, 5);
    check("done_hi", DONE, 1);
    @(negedge CLK);
    check("done_lo", DONE, 0);
    check("idle_state", {STATE, BUSY}, {3'd0, 1'b0});
    check("final_h", PW_MAX_H, v.exp_h);
    check("final_v", PW_MAX_V, v.exp_v);
  endtask

  initial begin
    int n;
    vecs[0] = '{12000, 900, -1, 0, 100, 20000, 800, 12000, 20000};
    vecs[1] = '{8000, 700, 15000, 700, 300, 25000, 1000, 8000, 25000};
    vecs[2] = '{-1, 0, -1, 0, 0, -1, 0, 5000, 5000};
    vecs[3] = '{9000, 600, 24000, 4000, 10, 5000, 4095, 24000, 5000};

    RST = 1'b1; START = 1'b1; IRR_VALID = 1'b1; IRR = 12'd50; PW_H = 0; PW_V = 0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST = 1'b0; START = 1'b0; IRR_VALID = 1'b0;
    @(negedge CLK);
    check("post_rst_idle", STATE, 0);

    for (int i = 0; i < 4; i++) run_cal(vecs[i]);

    // Abort mid vertical sweep; START held with RST must not launch a run.
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    drive_ramp(1'b1, vecs[0]);
    wait_leave(3'd2, 100, n);
    check("abort_vs", STATE, 3);
    PW_V = 6000; IRR = 12'd2000; IRR_VALID = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1; START = 1'b1;
    @(negedge CLK);
    check_reset_outputs("abort");
    RST = 1'b0; START = 1'b0; IRR_VALID = 1'b0;
    @(negedge CLK);
    check("abort_idle", STATE, 0);

    run_cal(vecs[1]);
    wait_leave(3'd0, 60, n);
`ifdef ST_AUTO_RECAL_EN
    check("recal_delay", n, 50);
    check("recal_state", STATE, 1);
`else
    check("no_recal_len", n, 60);
    check("no_recal_state", STATE, 0);
`endif
    check("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
